count_match_monitor: RTL and testbench

- Downstream consumer of the 4-bit free-running binary counter stage; samples its count output every clock.
- Detects programmable compare matches, counts counter wrap-arounds (15 to 0) into an extended wrap count, and detects upstream clears.
- Delivers one match event record per armed session over a valid/ready handshake to control logic.
- Counter, monitor and consumer all run on the same clock.

---
 rtl/count_match_monitor_pkg.sv | 25 ++
 rtl/count_match_monitor_if.sv | 28 ++
 rtl/count_match_monitor_count_edge_classifier.sv | 31 +++
 rtl/count_match_monitor.sv | 107 ++++++++++
 tb/tb_count_match_monitor.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/count_match_monitor_pkg.sv
// Shared types and helpers for the count match monitor.
// The classification functions are sized to the default count width.
package count_match_monitor_pkg;

  localparam int unsigned DEF_COUNT_W = 4;
  localparam int unsigned DEF_WRAP_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    HOLD  = 2'b10
  } state_e;

  function automatic logic is_wrap(input logic [DEF_COUNT_W-1:0] prev,
                                   input logic [DEF_COUNT_W-1:0] cur);
    return (prev == '1) && (cur == '0);
  endfunction

  // A drop to zero from anywhere except 0 or all-ones means the upstream counter was cleared.
  function automatic logic is_upstream_clear(input logic [DEF_COUNT_W-1:0] prev,
                                             input logic [DEF_COUNT_W-1:0] cur);
    return (cur == '0) && (prev != '0) && (prev != '1);
  endfunction

endpackage

// File: rtl/count_match_monitor_if.sv
// Count sample, arm/compare request and event handshake bundle.
interface count_match_monitor_if
  import count_match_monitor_pkg::*;
#(
  parameter int unsigned COUNT_W = DEF_COUNT_W,
  parameter int unsigned WRAP_W  = DEF_WRAP_W
);
  logic [COUNT_W-1:0] count_in;
  logic               arm;
  logic [COUNT_W-1:0] compare_val;
  logic               ev_ready;
  logic               ev_valid;
  logic [WRAP_W-1:0]  ev_wraps;
  logic               match_pulse;
  logic [WRAP_W-1:0]  wrap_count;
  logic               overrun;
  logic               busy;

  modport master (
    output count_in, arm, compare_val, ev_ready,
    input  ev_valid, ev_wraps, match_pulse, wrap_count, overrun, busy
  );

  modport slave (
    input  count_in, arm, compare_val, ev_ready,
    output ev_valid, ev_wraps, match_pulse, wrap_count, overrun, busy
  );
endinterface

// File: rtl/count_match_monitor_count_edge_classifier.sv
// Remembers the previous count sample and classifies the current transition.
module count_edge_classifier
  import count_match_monitor_pkg::*;
#(
  parameter int unsigned COUNT_W = DEF_COUNT_W
) (
  input  logic               clock_i,
  input  logic               clear_n_i,
  input  logic [COUNT_W-1:0] count_i,
  output logic               wrap_o,
  output logic               upstream_clear_o,
  output logic               changed_o
);
  logic [COUNT_W-1:0] prev_q;
  logic [COUNT_W-1:0] prev_d;

  always_comb begin
    prev_d = count_i;
  end

  always_ff @(posedge clock_i or negedge clear_n_i) begin
    if (!clear_n_i) prev_q <= '0;
    else            prev_q <= prev_d;
  end

  always_comb begin
    wrap_o           = is_wrap(prev_q, count_i);
    upstream_clear_o = is_upstream_clear(prev_q, count_i);
    changed_o        = (count_i != prev_q);
  end
endmodule

// File: rtl/count_match_monitor.sv
// Compare-match session FSM, wrap counter and single-entry event register
// fed by the upstream 4-bit counter.
module count_match_monitor
  import count_match_monitor_pkg::*;
#(
  parameter int unsigned COUNT_W = DEF_COUNT_W,
  parameter int unsigned WRAP_W  = DEF_WRAP_W
) (
  input logic                  clock,
  input logic                  clear_n,
  count_match_monitor_if.slave bus
);
  state_e             state_q, state_d;
  logic [COUNT_W-1:0] cmp_q, cmp_d;
  logic [WRAP_W-1:0]  wrap_q, wrap_d;
  logic [WRAP_W-1:0]  ev_wraps_q, ev_wraps_d;
  logic               ev_valid_q, ev_valid_d;
  logic               match_q, match_d;
  logic               overrun_q, overrun_d;
  logic               busy_q, busy_d;

  logic wrap_ev, clear_ev, changed, hit;

  count_edge_classifier #(.COUNT_W(COUNT_W)) u_class (
    .clock_i          (clock),
    .clear_n_i        (clear_n),
    .count_i          (bus.count_in),
    .wrap_o           (wrap_ev),
    .upstream_clear_o (clear_ev),
    .changed_o        (changed)
  );

  assign hit = (bus.count_in == cmp_q) && changed;

  always_comb begin
    wrap_d = wrap_q;
    if (clear_ev)     wrap_d = '0;
    else if (wrap_ev) wrap_d = wrap_q + 1'b1;
  end

  // ev_wraps samples wrap_d so a wrap on the matching cycle is counted.
  always_comb begin
    state_d    = state_q;
    cmp_d      = cmp_q;
    ev_wraps_d = ev_wraps_q;
    ev_valid_d = ev_valid_q;
    match_d    = 1'b0;
    overrun_d  = overrun_q;
    case (state_q)
      IDLE: begin
        if (bus.arm) begin
          cmp_d   = bus.compare_val;
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (hit) begin
          match_d    = 1'b1;
          ev_wraps_d = wrap_d;
          ev_valid_d = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (hit) begin
          match_d   = 1'b1;
          overrun_d = 1'b1;
        end
        if (ev_valid_q && bus.ev_ready) begin
          ev_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q    <= IDLE;
      cmp_q      <= '0;
      wrap_q     <= '0;
      ev_wraps_q <= '0;
      ev_valid_q <= 1'b0;
      match_q    <= 1'b0;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmp_q      <= cmp_d;
      wrap_q     <= wrap_d;
      ev_wraps_q <= ev_wraps_d;
      ev_valid_q <= ev_valid_d;
      match_q    <= match_d;
      overrun_q  <= overrun_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.ev_valid    = ev_valid_q;
  assign bus.ev_wraps    = ev_wraps_q;
  assign bus.match_pulse = match_q;
  assign bus.wrap_count  = wrap_q;
  assign bus.overrun     = overrun_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_count_match_monitor.sv
// Self-checking bench: directed table and sequences plus random traffic against a session-level model.
module tb_count_match_monitor;
  logic clock;
  logic clear_n;

  count_match_monitor_if #(.COUNT_W(4), .WRAP_W(8)) bus ();

  count_match_monitor #(.COUNT_W(4), .WRAP_W(8)) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  // Session-level reference model
  int m_prev, m_cmp, m_wrap, m_evw;
  bit m_waiting, m_pending, m_pulse, m_ovr;

  task automatic model_reset();
    m_prev = 0; m_cmp = 0; m_wrap = 0; m_evw = 0;
    m_waiting = 0; m_pending = 0; m_pulse = 0; m_ovr = 0;
  endtask

  task automatic model_clock(input int c, input bit a, input int cv, input bit r);
    bit wrapped, cleared, hit;
    int nw;
    wrapped = (m_prev == 15) && (c == 0);
    cleared = (c == 0) && (m_prev != 0) && (m_prev != 15);
    nw = cleared ? 0 : (wrapped ? (m_wrap + 1) % 256 : m_wrap);
    hit = (c == m_cmp) && (c != m_prev);
    m_pulse = 0;
    if (m_pending) begin
      if (hit) begin m_pulse = 1; m_ovr = 1; end
      if (r) m_pending = 0;
    end else if (m_waiting) begin
      if (hit) begin
        m_pulse = 1; m_evw = nw; m_pending = 1; m_waiting = 0;
      end
    end else if (a) begin
      m_cmp = cv; m_waiting = 1;
    end
    m_prev = c;
    m_wrap = nw;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("m_pulse",    int'(bus.match_pulse), int'(m_pulse));
    chk("m_ev_valid", int'(bus.ev_valid),    int'(m_pending));
    chk("m_ev_wraps", int'(bus.ev_wraps),    m_evw);
    chk("m_wrap_cnt", int'(bus.wrap_count),  m_wrap);
    chk("m_overrun",  int'(bus.overrun),     int'(m_ovr));
    chk("m_busy",     int'(bus.busy),        int'(m_waiting | m_pending));
  endtask

  task automatic step(input int c, input bit a, input int cv, input bit r);
    @(negedge clock);
    bus.count_in    = 4'(c);
    bus.arm         = a;
    bus.compare_val = 4'(cv);
    bus.ev_ready    = r;
    @(posedge clock);
    model_clock(c, a, cv, r);
    #1;
    if (bus.match_pulse) pulses++;
    chk_model();
  endtask

  typedef struct {
    int cnt; bit arm; int cmp; bit rdy;
    bit e_pulse; bit e_valid; int e_wraps; int e_wc; bit e_busy;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int p0;
    tbl[0] = '{cnt:2, arm:1, cmp:5, rdy:1, e_pulse:0, e_valid:0, e_wraps:0, e_wc:2, e_busy:1};
    tbl[1] = '{cnt:3, arm:0, cmp:0, rdy:1, e_pulse:0, e_valid:0, e_wraps:0, e_wc:2, e_busy:1};
    tbl[2] = '{cnt:4, arm:0, cmp:0, rdy:1, e_pulse:0, e_valid:0, e_wraps:0, e_wc:2, e_busy:1};
    tbl[3] = '{cnt:5, arm:0, cmp:0, rdy:1, e_pulse:1, e_valid:1, e_wraps:2, e_wc:2, e_busy:1};
    tbl[4] = '{cnt:6, arm:1, cmp:6, rdy:1, e_pulse:0, e_valid:0, e_wraps:2, e_wc:2, e_busy:0};
    tbl[5] = '{cnt:7, arm:0, cmp:0, rdy:1, e_pulse:0, e_valid:0, e_wraps:2, e_wc:2, e_busy:0};

    clear_n = 1'b0;
    bus.count_in = '0; bus.arm = 1'b0; bus.compare_val = '0; bus.ev_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", int'(bus.ev_valid), 0);
    chk("rst_wraps", int'(bus.ev_wraps), 0);
    chk("rst_pulse", int'(bus.match_pulse), 0);
    chk("rst_wc",    int'(bus.wrap_count), 0);
    chk("rst_ovr",   int'(bus.overrun), 0);
    chk("rst_busy",  int'(bus.busy), 0);
    @(negedge clock);
    clear_n = 1'b1;

    // Free run, no arm: two wraps, no events
    for (int i = 0; i < 36; i++) step(i % 16, 0, 0, 0);
    chk("run_wc", int'(bus.wrap_count), 2);
    chk("run_valid", int'(bus.ev_valid), 0);
    chk("run_busy", int'(bus.busy), 0);
    chk("run_pulses", pulses, 0);

    // Basic session with consumer always ready
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].cnt, tbl[i].arm, tbl[i].cmp, tbl[i].rdy);
      chk("tbl_pulse", int'(bus.match_pulse), int'(tbl[i].e_pulse));
      chk("tbl_valid", int'(bus.ev_valid), int'(tbl[i].e_valid));
      chk("tbl_wraps", int'(bus.ev_wraps), tbl[i].e_wraps);
      chk("tbl_wc", int'(bus.wrap_count), tbl[i].e_wc);
      chk("tbl_busy", int'(bus.busy), int'(tbl[i].e_busy));
    end

    // Match on 0 coinciding with a wrap
    for (int c = 8; c < 16; c++) step(c, 0, 0, 1);
    for (int c = 0; c < 14; c++) step(c, 0, 0, 1);
    chk("wrap3", int'(bus.wrap_count), 3);
    step(14, 1, 0, 1);
    step(15, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("coinc_pulse", int'(bus.match_pulse), 1);
    chk("coinc_evw", int'(bus.ev_wraps), 4);
    chk("coinc_wc", int'(bus.wrap_count), 4);
    step(1, 0, 0, 1);
    chk("coinc_idle", int'(bus.busy), 0);

    // Held event with a second match -> overrun
    step(2, 1, 7, 0);
    for (int c = 3; c < 8; c++) step(c, 0, 0, 0);
    chk("hold_pulse1", int'(bus.match_pulse), 1);
    chk("hold_evw1", int'(bus.ev_wraps), 4);
    for (int i = 8; i < 24; i++) begin
      step(i % 16, 0, 0, 0);
      chk("hold_valid", int'(bus.ev_valid), 1);
    end
    chk("ovr_set", int'(bus.overrun), 1);
    chk("ovr_pulse", int'(bus.match_pulse), 1);
    chk("ovr_evw", int'(bus.ev_wraps), 4);
    chk("ovr_wc", int'(bus.wrap_count), 5);
    step(8, 0, 0, 1);
    chk("hs_valid", int'(bus.ev_valid), 0);
    chk("hs_busy", int'(bus.busy), 0);
    chk("ovr_sticky", int'(bus.overrun), 1);

    // Upstream clear, then stalled counter on the match value
    for (int c = 9; c < 16; c++) step(c, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int c = 1; c < 10; c++) step(c, 0, 0, 0);
    chk("pre_clr_wc", int'(bus.wrap_count), 6);
    step(0, 0, 0, 0);
    chk("clr_wc", int'(bus.wrap_count), 0);
    p0 = pulses;
    step(1, 1, 5, 0);
    for (int c = 2; c < 5; c++) step(c, 0, 0, 0);
    repeat (4) step(5, 0, 0, 0);
    chk("stall_pulses", pulses - p0, 1);
    chk("stall_valid", int'(bus.ev_valid), 1);

    // Asynchronous reset in the middle of HOLD
    @(posedge clock);
    #3;
    clear_n = 1'b0;
    model_reset();
    #1;
    chk("arst_valid", int'(bus.ev_valid), 0);
    chk("arst_wraps", int'(bus.ev_wraps), 0);
    chk("arst_pulse", int'(bus.match_pulse), 0);
    chk("arst_wc",    int'(bus.wrap_count), 0);
    chk("arst_ovr",   int'(bus.overrun), 0);
    chk("arst_busy",  int'(bus.busy), 0);
    @(negedge clock);
    clear_n = 1'b1;
    p0 = pulses;
    for (int i = 6; i < 26; i++) step(i % 16, 0, 0, i[0]);
    chk("post_rst_pulses", pulses - p0, 0);
    chk("post_rst_valid", int'(bus.ev_valid), 0);

    // Random traffic against the model
    begin
      int c;
      c = 9;
      for (int i = 0; i < 400; i++) begin
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 70)      c = (c + 1) % 16;
        else if (r < 85) c = c;
        else if (r < 93) c = 0;
        else             c = int'($urandom_range(0, 15));
        step(c, ($urandom_range(0, 4) == 0), int'($urandom_range(0, 15)),
             bit'($urandom_range(0, 1)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
